// File: rtl/pid_pkg.sv
// Shared types and widths for the PID error sequencer.
// Term widths are sized for gains of 0..15 on a 10-bit signed error.
package pid_pkg;

  localparam int ERR_W   = 10;          // saturated error sample
  localparam int DIFF_W  = ERR_W + 1;   // raw err - prev_err
  localparam int DSAT_W  = 7;           // clamped difference fed to the D multiply
  localparam int DTERM_W = 13;          // D term
  localparam int INT_W   = 15;          // integrator
  localparam int OUT_W   = 14;          // P term, product and pid_out
  localparam int ACC_W   = 16;          // headroom for integrator and term sums
  localparam int COEF_W  = 6;           // signed gain coefficients

  typedef enum logic [2:0] {
    IDLE,
    S_P,
    S_D,
    S_I,
    S_SUM
  } pid_state_t;

endpackage

// File: rtl/sat_signed.sv
// Clamps a signed IN_W-bit value into the signed OUT_W-bit range.
module sat_signed #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 14
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // In range exactly when every bit above the result's sign bit matches it.
  logic in_range;

  always_comb begin
    in_range = (&din[IN_W-1:OUT_W-1]) || (~|din[IN_W-1:OUT_W-1]);
    if (in_range) begin
      dout = din[OUT_W-1:0];
    end else if (din[IN_W-1]) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/pid_seq_ctrl.sv
// PID error sequencer: one shared signed multiplier for P and D, a saturating
// integrator, and a saturated 14-bit sum, one sample per five cycles.
module pid_seq_ctrl
  import pid_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] P_COEFF = 6'sh0B,
  parameter logic signed [COEF_W-1:0] D_COEFF = 6'sh07,
  parameter int                       I_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ERR_W-1:0] err_sat,
  input  logic                    err_vld,
  input  logic                    int_clr,
  input  logic                    clr_ovr,
  output logic signed [OUT_W-1:0] pid_out,
  output logic                    pid_vld,
  output logic                    busy,
  output logic                    ovr
);

  localparam int ITERM_W = INT_W - I_SHIFT;

  pid_state_t                 state_q, state_d;
  logic signed [ERR_W-1:0]    err_q, err_d;
  logic signed [ERR_W-1:0]    prev_err_q, prev_err_d;
  logic signed [OUT_W-1:0]    p_term_q, p_term_d;
  logic signed [DTERM_W-1:0]  d_term_q, d_term_d;
  logic signed [INT_W-1:0]    integ_q, integ_d;
  logic signed [ITERM_W-1:0]  i_term_q, i_term_d;
  logic signed [OUT_W-1:0]    pid_out_q, pid_out_d;
  logic                       pid_vld_q, pid_vld_d;
  logic                       busy_q, busy_d;
  logic                       ovr_q, ovr_d;

  logic signed [DIFF_W-1:0]   diff;
  logic signed [DSAT_W-1:0]   diff_sat;
  logic signed [ERR_W-1:0]    mult_a;
  logic signed [COEF_W-1:0]   mult_b;
  logic signed [OUT_W-1:0]    product;
  logic signed [ACC_W-1:0]    integ_sum;
  logic signed [INT_W-1:0]    integ_sat;
  logic signed [INT_W-1:0]    integ_new;
  logic signed [ITERM_W-1:0]  i_term_new;
  logic signed [ACC_W-1:0]    term_sum;
  logic signed [OUT_W-1:0]    term_sum_sat;

  sat_signed #(.IN_W(DIFF_W), .OUT_W(DSAT_W)) u_sat_diff (
    .din  (diff),
    .dout (diff_sat)
  );

  sat_signed #(.IN_W(ACC_W), .OUT_W(INT_W)) u_sat_integ (
    .din  (integ_sum),
    .dout (integ_sat)
  );

  sat_signed #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_sum (
    .din  (term_sum),
    .dout (term_sum_sat)
  );

  // Datapath: the single multiplier sees err_q in S_P and diff_sat in S_D.
  // With gains limited to 0..15 the product never exceeds the 14-bit range.
  always_comb begin
    diff      = DIFF_W'(err_q) - DIFF_W'(prev_err_q);
    mult_a    = (state_q == S_D) ? ERR_W'(diff_sat) : err_q;
    mult_b    = (state_q == S_D) ? D_COEFF : P_COEFF;
    product   = OUT_W'(mult_a) * OUT_W'(mult_b);

    integ_sum = ACC_W'(integ_q) + ACC_W'(err_q);
    if (int_clr) begin
      integ_new  = '0;
      i_term_new = '0;
    end else begin
      integ_new  = integ_sat;
      i_term_new = ITERM_W'(integ_sat >>> I_SHIFT);
    end

    // The final add runs alongside the integrator update so the result
    // lands in pid_out as the FSM enters S_SUM, four cycles after err_vld.
    term_sum  = ACC_W'(p_term_q) + ACC_W'(d_term_q) + ACC_W'(i_term_new);
  end

  // NOTE: every _d takes its held value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    prev_err_d = prev_err_q;
    p_term_d   = p_term_q;
    d_term_d   = d_term_q;
    integ_d    = integ_q;
    i_term_d   = i_term_q;
    pid_out_d  = pid_out_q;
    pid_vld_d  = 1'b0;
    ovr_d      = ovr_q;

    // A set in the same cycle as clr_ovr wins because it is applied last.
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (err_vld && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    if (int_clr) begin
      integ_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (err_vld) begin
          err_d   = err_sat;
          state_d = S_P;
        end
      end
      S_P: begin
        p_term_d = product;
        state_d  = S_D;
      end
      S_D: begin
        d_term_d   = product[DTERM_W-1:0];
        prev_err_d = err_q;
        state_d    = S_I;
      end
      S_I: begin
        integ_d   = integ_new;
        i_term_d  = i_term_new;
        pid_out_d = term_sum_sat;
        pid_vld_d = 1'b1;
        state_d   = S_SUM;
      end
      S_SUM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: non-blocking assignments keep every flop sampling the pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      err_q      <= '0;
      prev_err_q <= '0;
      p_term_q   <= '0;
      d_term_q   <= '0;
      integ_q    <= '0;
      i_term_q   <= '0;
      pid_out_q  <= '0;
      pid_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      prev_err_q <= prev_err_d;
      p_term_q   <= p_term_d;
      d_term_q   <= d_term_d;
      integ_q    <= integ_d;
      i_term_q   <= i_term_d;
      pid_out_q  <= pid_out_d;
      pid_vld_q  <= pid_vld_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign pid_out = pid_out_q;
  assign pid_vld = pid_vld_q;
  assign busy    = busy_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_pid_seq_ctrl.sv
// Directed bench for pid_seq_ctrl with hand-computed expected results.
module tb_pid_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [9:0]  err_sat;
  logic               err_vld;
  logic               int_clr;
  logic               clr_ovr;
  logic signed [13:0] pid_out;
  logic               pid_vld;
  logic               busy;
  logic               ovr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pid_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .err_sat (err_sat),
    .err_vld (err_vld),
    .int_clr (int_clr),
    .clr_ovr (clr_ovr),
    .pid_out (pid_out),
    .pid_vld (pid_vld),
    .busy    (busy),
    .ovr     (ovr)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send(input logic signed [9:0] e);
    @(negedge clk);
    err_sat = e;
    err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
  endtask

  // One sample; k counts negedges after the accepting edge. An optional
  // side-band pulse is driven at negedge inj_k (sampled at the next edge).
  task automatic run(input logic signed [9:0] e, input logic signed [13:0] exp,
                     input string tag, input bit do_chk = 1'b1,
                     input int inj_k = 0, input bit inj_vld = 1'b0,
                     input bit inj_clr_ovr = 1'b0, input bit inj_int_clr = 1'b0);
    int lat = 0;
    int nb  = 0;
    int nv  = 0;
    logic signed [13:0] got = 'x;
    send(e);
    for (int k = 1; k <= 6; k++) begin
      if (busy) nb++;
      if (pid_vld) begin
        nv++;
        if (lat == 0) begin
          lat = k;
          got = pid_out;
        end
      end
      err_vld = (k == inj_k) && inj_vld;
      clr_ovr = (k == inj_k) && inj_clr_ovr;
      int_clr = (k == inj_k) && inj_int_clr;
      if (k == inj_k) err_sat = -10'sd300;
      if (k < 6) @(negedge clk);
    end
    if (do_chk) begin
      check({tag, "_lat"}, lat, 4);
      check({tag, "_busy_cycles"}, nb, 4);
      check({tag, "_vld_pulses"}, nv, 1);
      check({tag, "_pid_out"}, got, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    err_sat = '0;
    err_vld = 1'b0;
    int_clr = 1'b0;
    clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_pid_out", pid_out, 0);
    check("rst_pid_vld", pid_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", ovr, 0);

    // P=1100, D=63*7=441, I=100>>>4=6
    run(100, 1547, "t1");
    // D=0, I=200>>>4=12; overrun injected while in S_D
    run(100, 1112, "t2", 1'b1, 2, 1'b1, 1'b0, 1'b0);
    check("t3_ovr_set", ovr, 1);
    check("t3_hold", pid_out, 1112);
    @(negedge clk) clr_ovr = 1'b1;
    @(negedge clk) clr_ovr = 1'b0;
    check("t3_ovr_clr", ovr, 0);

    // 5621 + 441 + (711>>>4=44)
    run(511, 6106, "t4a");
    // -5632 + (-64*7) + (199>>>4=12); overrun in S_SUM together with clr_ovr
    run(-512, -6068, "t4b", 1'b1, 4, 1'b1, 1'b1, 1'b0);
    check("t4_set_wins", ovr, 1);
    @(negedge clk) clr_ovr = 1'b1;
    @(negedge clk) clr_ovr = 1'b0;
    check("t4_ovr_clr", ovr, 0);

    // Integrator clamps at 16383 -> I=1023; last sample 5621 + 0 + 1023
    for (int i = 0; i < 39; i++) run(511, 0, "t5", 1'b0);
    run(511, 6644, "t5_sat");
    @(negedge clk) int_clr = 1'b1;
    @(negedge clk) int_clr = 1'b0;
    // Integrator cleared; only D remains: diff=-511 -> -64, -448
    run(0, -448, "t5_clr");
    run(0, 0, "t5_zero");

    run(100, 1547, "t7a");
    // int_clr during S_I: I=0, so 1100 + 0 + 0
    run(100, 1100, "t7_iclr", 1'b1, 3, 1'b0, 1'b0, 1'b1);
    // integ restarts from 0: 100>>>4=6
    run(100, 1106, "t7b");

    // Reset while in S_D, with ovr set by a second strobe in S_P
    @(negedge clk);
    err_sat = 300;
    err_vld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    err_vld = 1'b0;
    check("t6_busy_pre", busy, 1);
    check("t6_ovr_pre", ovr, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_ovr", ovr, 0);
    check("t6_pid_out", pid_out, 0);
    begin
      int nv = 0;
      for (int k = 0; k < 6; k++) begin
        if (pid_vld) nv++;
        @(negedge clk);
      end
      check("t6_no_vld", nv, 0);
    end
    run(100, 1547, "t6_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
